// File: rtl/ctrl_sequencer.sv
`default_nettype none
//--------------------------------------------------------------------------
// ctrl_sequencer : falling-edge instruction sequencer, memory wait + timeout
// Revision 1.0
//--------------------------------------------------------------------------
module ctrl_sequencer #(
   parameter int             OPW      = 3,
   parameter logic [OPW-1:0] HLT      = OPW'(0),
   parameter logic [OPW-1:0] SKZ      = OPW'(1),
   parameter logic [OPW-1:0] ADD      = OPW'(2),
   parameter logic [OPW-1:0] ANDD     = OPW'(3),
   parameter logic [OPW-1:0] XORR     = OPW'(4),
   parameter logic [OPW-1:0] LDA      = OPW'(5),
   parameter logic [OPW-1:0] STO      = OPW'(6),
   parameter logic [OPW-1:0] JMP      = OPW'(7),
   parameter int             WAIT_MAX = 15,
   parameter int             CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [OPW-1:0]   opcode_c,
   input  logic             zero,
   input  logic             mem_rdy,
   input  logic             resume,
   output logic             inc_pc,
   output logic             load_acc,
   output logic             load_pc,
   output logic             rd,
   output logic             wr,
   output logic             load_ir,
   output logic             datactl_ena,
   output logic             halt,
   output logic             err,
   output logic [3:0]       state_o,
   output logic [CNT_W-1:0] instr_cnt
);

   typedef enum logic [3:0] {
      FETCH0 = 4'd0,
      FETCH1 = 4'd1,
      IDLE   = 4'd2,
      DEC    = 4'd3,
      OP1    = 4'd4,
      OP2    = 4'd5,
      OP3    = 4'd6,
      OP4    = 4'd7,
      HALT   = 4'd8,
      ERR    = 4'd9
   } state_t;

   typedef struct packed {
      logic inc_pc;
      logic load_acc;
      logic load_pc;
      logic rd;
      logic wr;
      logic load_ir;
      logic datactl_ena;
      logic halt;
      logic err;
   } ctl_t;

   localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

   state_t            state_q, state_d;
   logic [7:0]        wait_q, wait_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   ctl_t              ctl_q, ctl_d;
   logic              illegal;
   logic              mem_state;
   logic              strobe_ok;

   // Moore control decode for the state being entered, using inputs at that edge
   function automatic ctl_t decode(input state_t s, input logic [OPW-1:0] op, input logic z);
      ctl_t c;
      logic alu_ld;
      c      = '0;
      alu_ld = (op == ADD) || (op == ANDD) || (op == XORR) || (op == LDA);
      case (s)
         FETCH0: begin
            c.rd      = 1'b1;
            c.load_ir = 1'b1;
         end
         FETCH1: begin
            c.inc_pc  = 1'b1;
            c.rd      = 1'b1;
            c.load_ir = 1'b1;
         end
         DEC: begin
            c.inc_pc = 1'b1;
            c.halt   = (op == HLT);
         end
         OP1: begin
            c.load_pc     = (op == JMP);
            c.rd          = alu_ld;
            c.datactl_ena = (op == STO);
         end
         OP2: begin
            c.load_acc    = alu_ld;
            c.rd          = alu_ld;
            c.inc_pc      = ((op == SKZ) && z) || (op == JMP);
            c.load_pc     = (op == JMP);
            c.wr          = (op == STO);
            c.datactl_ena = (op == STO);
         end
         OP3: begin
            c.datactl_ena = (op == STO);
            c.rd          = alu_ld;
         end
         OP4: begin
            c.inc_pc = (op == SKZ) && z;
         end
         HALT: begin
            c.halt = 1'b1;
         end
         ERR: begin
            c.halt = 1'b1;
            c.err  = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   assign mem_state = ctl_q.rd | ctl_q.wr;

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      cnt_d   = cnt_q;
      ctl_d   = ctl_q;
      illegal = 1'b0;
      if (!ena) begin
         state_d = FETCH0;
         wait_d  = '0;
         ctl_d   = '0;
      end else if (mem_state && !mem_rdy) begin
         // stalled on memory: hold state and controls until ready or timeout
         if (wait_q == WAIT_LIM) begin
            state_d = ERR;
            wait_d  = '0;
            ctl_d   = decode(ERR, opcode_c, zero);
         end else begin
            wait_d = wait_q + 8'd1;
         end
      end else begin
         wait_d = '0;
         case (state_q)
            FETCH0: state_d = FETCH1;
            FETCH1: state_d = IDLE;
            IDLE:   state_d = DEC;
            DEC:    state_d = (opcode_c == HLT) ? HALT : OP1;
            OP1:    state_d = OP2;
            OP2:    state_d = OP3;
            OP3:    state_d = OP4;
            OP4: begin
               state_d = FETCH0;
               cnt_d   = cnt_q + CNT_W'(1);
            end
            HALT:   state_d = resume ? FETCH0 : HALT;
            ERR:    state_d = ERR;
            default: begin
               state_d = FETCH0;
               illegal = 1'b1;
            end
         endcase
         ctl_d = illegal ? '0 : decode(state_d, opcode_c, zero);
      end
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH0;
         wait_q  <= '0;
         cnt_q   <= '0;
         ctl_q   <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         cnt_q   <= cnt_d;
         ctl_q   <= ctl_d;
      end
   end

   // load strobes fire only in the cycle the memory access is accepted
   assign strobe_ok   = mem_rdy | ~mem_state;
   assign inc_pc      = ctl_q.inc_pc   & strobe_ok;
   assign load_acc    = ctl_q.load_acc & strobe_ok;
   assign load_pc     = ctl_q.load_pc  & strobe_ok;
   assign load_ir     = ctl_q.load_ir  & strobe_ok;
   assign rd          = ctl_q.rd;
   assign wr          = ctl_q.wr;
   assign datactl_ena = ctl_q.datactl_ena;
   assign halt        = ctl_q.halt;
   assign err         = ctl_q.err;
   assign state_o     = state_q;
   assign instr_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_sequencer.sv
`default_nettype none
// tb_ctrl_sequencer : vector table, directed corner sequences and a randomized
// run against a behavioural model of the sequencer.
module tb_ctrl_sequencer;

   localparam int WAIT_MAX = 15;

   localparam logic [2:0] O_HLT = 3'd0, O_SKZ = 3'd1, O_ADD = 3'd2, O_AND = 3'd3,
                          O_XOR = 3'd4, O_LDA = 3'd5, O_STO = 3'd6, O_JMP = 3'd7;

   // control vector order: inc_pc load_acc load_pc rd wr load_ir datactl_ena halt err
   localparam logic [8:0] C_INC = 9'h100, C_ACC = 9'h080, C_LPC = 9'h040, C_RD  = 9'h020,
                          C_WR  = 9'h010, C_IR  = 9'h008, C_DAT = 9'h004, C_HLT = 9'h002,
                          C_ERR = 9'h001;

   localparam logic [3:0] S_F0 = 4'd0, S_F1 = 4'd1, S_IDLE = 4'd2, S_DEC = 4'd3,
                          S_OP1 = 4'd4, S_OP2 = 4'd5, S_OP3 = 4'd6, S_OP4 = 4'd7,
                          S_HALT = 4'd8, S_ERR = 4'd9;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        ena = 1'b0;
   logic        zero = 1'b0;
   logic        mem_rdy = 1'b0;
   logic        resume = 1'b0;
   logic [2:0]  opcode_c = 3'd0;

   logic        inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt, err;
   logic [3:0]  state_o;
   logic [15:0] instr_cnt;
   logic [8:0]  ctl_vis;

   logic        inc_pc4, load_acc4, load_pc4, rd4, wr4, load_ir4, datactl_ena4, halt4, err4;
   logic [3:0]  state_o4;
   logic [3:0]  instr_cnt4;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ctrl_sequencer #(.WAIT_MAX(WAIT_MAX), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .opcode_c(opcode_c), .zero(zero),
      .mem_rdy(mem_rdy), .resume(resume),
      .inc_pc(inc_pc), .load_acc(load_acc), .load_pc(load_pc), .rd(rd), .wr(wr),
      .load_ir(load_ir), .datactl_ena(datactl_ena), .halt(halt), .err(err),
      .state_o(state_o), .instr_cnt(instr_cnt)
   );

   ctrl_sequencer #(.WAIT_MAX(WAIT_MAX), .CNT_W(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .opcode_c(opcode_c), .zero(zero),
      .mem_rdy(mem_rdy), .resume(resume),
      .inc_pc(inc_pc4), .load_acc(load_acc4), .load_pc(load_pc4), .rd(rd4), .wr(wr4),
      .load_ir(load_ir4), .datactl_ena(datactl_ena4), .halt(halt4), .err(err4),
      .state_o(state_o4), .instr_cnt(instr_cnt4)
   );

   assign ctl_vis = {inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt, err};

   // ---------------- behavioural reference model ----------------
   logic [3:0]  ms;
   logic [7:0]  mw;
   logic [15:0] mc;
   logic [8:0]  mctl;

   function automatic logic [8:0] spec_ctl(input int s, input logic [2:0] op, input logic z);
      logic alu;
      alu = (op == O_ADD) || (op == O_AND) || (op == O_XOR) || (op == O_LDA);
      case (s)
         0: return C_RD | C_IR;
         1: return C_INC | C_RD | C_IR;
         3: return C_INC | ((op == O_HLT) ? C_HLT : 9'd0);
         4: begin
            if (op == O_JMP) return C_LPC;
            if (alu)         return C_RD;
            if (op == O_STO) return C_DAT;
            return 9'd0;
         end
         5: begin
            if (alu)                return C_ACC | C_RD;
            if ((op == O_SKZ) && z) return C_INC;
            if (op == O_JMP)        return C_INC | C_LPC;
            if (op == O_STO)        return C_WR | C_DAT;
            return 9'd0;
         end
         6: begin
            if (op == O_STO) return C_DAT;
            if (alu)         return C_RD;
            return 9'd0;
         end
         7: return ((op == O_SKZ) && z) ? C_INC : 9'd0;
         8: return C_HLT;
         9: return C_HLT | C_ERR;
         default: return 9'd0;
      endcase
   endfunction

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ms   <= 4'd0;
         mw   <= 8'd0;
         mc   <= 16'd0;
         mctl <= 9'd0;
      end else begin : step
         logic busy;
         int   nxt;
         busy = (mctl & (C_RD | C_WR)) != 9'd0;
         if (!ena) begin
            ms   <= 4'd0;
            mw   <= 8'd0;
            mctl <= 9'd0;
         end else if (busy && !mem_rdy) begin
            if (mw == 8'(WAIT_MAX)) begin
               ms   <= S_ERR;
               mw   <= 8'd0;
               mctl <= C_HLT | C_ERR;
            end else begin
               mw <= mw + 8'd1;
            end
         end else begin
            if (ms < 4'd8)        nxt = (ms == S_DEC && opcode_c == O_HLT) ? 8 : (int'(ms) + 1) % 8;
            else if (ms == S_HALT) nxt = resume ? 0 : 8;
            else                   nxt = 9;
            if (ms == S_OP4) mc <= mc + 16'd1;
            ms   <= 4'(nxt);
            mw   <= 8'd0;
            mctl <= spec_ctl(nxt, opcode_c, zero);
         end
      end
   end

   // ---------------- helpers ----------------
   typedef struct {
      logic        e, m;
      logic [2:0]  op;
      logic        z, r;
      logic [3:0]  st;
      logic [8:0]  ctl;
      logic [15:0] cnt;
   } vec_t;

   vec_t tbl[$];

   task automatic push(input logic e, input logic m, input logic [2:0] op, input logic z,
                       input logic r, input logic [3:0] st, input logic [8:0] ctl,
                       input logic [15:0] cnt);
      vec_t v;
      v.e = e; v.m = m; v.op = op; v.z = z; v.r = r; v.st = st; v.ctl = ctl; v.cnt = cnt;
      tbl.push_back(v);
   endtask

   // one full instruction with mem_rdy=1: FETCH1 .. OP4, then the next FETCH0
   task automatic add_instr(input logic [2:0] op, input logic z, input logic [8:0] c1,
                            input logic [8:0] c2, input logic [8:0] c3, input logic [8:0] c4,
                            input logic [15:0] cnt);
      push(1'b1, 1'b1, op, z, 1'b0, S_F1,   C_INC | C_RD | C_IR, cnt);
      push(1'b1, 1'b1, op, z, 1'b0, S_IDLE, 9'd0,                cnt);
      push(1'b1, 1'b1, op, z, 1'b0, S_DEC,  C_INC,               cnt);
      push(1'b1, 1'b1, op, z, 1'b0, S_OP1,  c1,                  cnt);
      push(1'b1, 1'b1, op, z, 1'b0, S_OP2,  c2,                  cnt);
      push(1'b1, 1'b1, op, z, 1'b0, S_OP3,  c3,                  cnt);
      push(1'b1, 1'b1, op, z, 1'b0, S_OP4,  c4,                  cnt);
      push(1'b1, 1'b1, op, z, 1'b0, S_F0,   C_RD | C_IR,         cnt + 16'd1);
   endtask

   // drive inputs just after the active (falling) edge, sample on the rising edge
   task automatic cyc(input logic e, input logic m, input logic [2:0] op, input logic z,
                      input logic r);
      @(negedge clk);
      #1;
      ena = e; mem_rdy = m; opcode_c = op; zero = z; resume = r;
      @(posedge clk);
   endtask

   task automatic chk(input string name, input logic [3:0] st, input logic [8:0] ctl,
                      input logic [15:0] cnt);
      n_cmp++;
      if (state_o !== st || ctl_vis !== ctl || instr_cnt !== cnt) begin
         n_bad++;
         $display("FAIL %s: got state=%0d ctl=%b cnt=%0d, want state=%0d ctl=%b cnt=%0d",
                  name, state_o, ctl_vis, instr_cnt, st, ctl, cnt);
      end
   endtask

   task automatic chk4(input string name, input logic [3:0] cnt);
      n_cmp++;
      if (instr_cnt4 !== cnt) begin
         n_bad++;
         $display("FAIL %s: got cnt4=%0d, want %0d", name, instr_cnt4, cnt);
      end
   endtask

   task automatic cmp_model(input int cycle);
      logic [8:0] vis;
      vis = mctl;
      if (((mctl & (C_RD | C_WR)) != 9'd0) && !mem_rdy)
         vis = vis & ~(C_INC | C_ACC | C_LPC | C_IR);
      n_cmp++;
      if ({state_o, ctl_vis, instr_cnt} !== {ms, vis, mc}) begin
         n_bad++;
         $display("FAIL rand@%0d: got state=%0d ctl=%b cnt=%0d, want state=%0d ctl=%b cnt=%0d",
                  cycle, state_o, ctl_vis, instr_cnt, ms, vis, mc);
      end
      chk4($sformatf("rand_cnt4@%0d", cycle), mc[3:0]);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      logic stuck;
      logic [2:0] rop;

      // vector table
      push(1'b1, 1'b1, O_LDA, 1'b0, 1'b0, S_F0, 9'd0, 16'd0);
      add_instr(O_LDA, 1'b0, C_RD,  C_ACC | C_RD,  C_RD,  9'd0,  16'd0);
      add_instr(O_SKZ, 1'b1, 9'd0,  C_INC,         9'd0,  C_INC, 16'd1);
      add_instr(O_SKZ, 1'b0, 9'd0,  9'd0,          9'd0,  9'd0,  16'd2);
      add_instr(O_JMP, 1'b0, C_LPC, C_INC | C_LPC, 9'd0,  9'd0,  16'd3);
      add_instr(O_ADD, 1'b0, C_RD,  C_ACC | C_RD,  C_RD,  9'd0,  16'd4);
      add_instr(O_XOR, 1'b1, C_RD,  C_ACC | C_RD,  C_RD,  9'd0,  16'd5);
      add_instr(O_STO, 1'b0, C_DAT, C_WR | C_DAT,  C_DAT, 9'd0,  16'd6);

      // asynchronous reset before any clock activity
      #1 rst_n = 1'b0;
      #1 chk("reset", S_F0, 9'd0, 16'd0);
      chk4("reset_cnt4", 4'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;

      foreach (tbl[i]) begin
         cyc(tbl[i].e, tbl[i].m, tbl[i].op, tbl[i].z, tbl[i].r);
         chk($sformatf("vec%0d", i), tbl[i].st, tbl[i].ctl, tbl[i].cnt);
      end

      // STO stalled three cycles in OP2
      cyc(1, 1, O_STO, 0, 0); chk("sto_f1",  S_F1,   C_INC | C_RD | C_IR, 16'd7);
      cyc(1, 1, O_STO, 0, 0); chk("sto_idle", S_IDLE, 9'd0,  16'd7);
      cyc(1, 1, O_STO, 0, 0); chk("sto_dec", S_DEC,  C_INC, 16'd7);
      cyc(1, 1, O_STO, 0, 0); chk("sto_op1", S_OP1,  C_DAT, 16'd7);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, O_STO, 0, 0); chk($sformatf("sto_wait%0d", i), S_OP2, C_WR | C_DAT, 16'd7);
      end
      cyc(1, 1, O_STO, 0, 0); chk("sto_op2_acc", S_OP2, C_WR | C_DAT, 16'd7);
      cyc(1, 1, O_STO, 0, 0); chk("sto_op3", S_OP3, C_DAT, 16'd7);
      cyc(1, 1, O_STO, 0, 0); chk("sto_op4", S_OP4, 9'd0,  16'd7);

      // memory never ready in FETCH0: 16 cycles there, then ERR
      for (int i = 0; i < 16; i++) begin
         cyc(1, 0, O_STO, 0, 0); chk($sformatf("to_f0_%0d", i), S_F0, C_RD, 16'd8);
      end
      cyc(1, 0, O_STO, 0, 0); chk("to_err",        S_ERR, C_HLT | C_ERR, 16'd8);
      cyc(1, 1, O_STO, 0, 1); chk("to_err_resume", S_ERR, C_HLT | C_ERR, 16'd8);
      cyc(0, 1, O_STO, 0, 0); chk("to_err_ena0",   S_ERR, C_HLT | C_ERR, 16'd8);
      cyc(1, 1, O_HLT, 0, 0); chk("to_exit",       S_F0,  9'd0,          16'd8);

      // HLT: sticky halt, resume ignored outside HALT
      cyc(1, 1, O_HLT, 0, 0); chk("hlt_f1",   S_F1,   C_INC | C_RD | C_IR, 16'd8);
      cyc(1, 1, O_HLT, 0, 1); chk("hlt_idle", S_IDLE, 9'd0,          16'd8);
      cyc(1, 1, O_HLT, 0, 0); chk("hlt_dec",  S_DEC,  C_INC | C_HLT, 16'd8);
      for (int i = 0; i < 20; i++) begin
         cyc(1, 1, O_HLT, 0, 0); chk($sformatf("hlt_hold%0d", i), S_HALT, C_HLT, 16'd8);
      end
      cyc(1, 1, O_HLT, 0, 1); chk("hlt_resume", S_HALT, C_HLT,       16'd8);
      cyc(1, 1, O_LDA, 0, 0); chk("hlt_f0",     S_F0,   C_RD | C_IR, 16'd8);

      // asynchronous reset during an OP2 stall
      cyc(1, 1, O_LDA, 0, 0); chk("rst_f1",  S_F1,   C_INC | C_RD | C_IR, 16'd8);
      cyc(1, 1, O_LDA, 0, 0); chk("rst_idle", S_IDLE, 9'd0,  16'd8);
      cyc(1, 1, O_LDA, 0, 0); chk("rst_dec", S_DEC,  C_INC, 16'd8);
      cyc(1, 1, O_LDA, 0, 0); chk("rst_op1", S_OP1,  C_RD,  16'd8);
      cyc(1, 0, O_LDA, 0, 0); chk("rst_op2_gated", S_OP2, C_RD, 16'd8);
      #2 rst_n = 1'b0;
      #1 chk("rst_async", S_F0, 9'd0, 16'd0);
      ena = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b1;
      cyc(1, 1, O_LDA, 0, 0); chk("rst_hold_f0",  S_F0, 9'd0, 16'd0);
      cyc(1, 1, O_LDA, 0, 0); chk("rst_first_adv", S_F1, C_INC | C_RD | C_IR, 16'd0);

      // 16 instructions: 4-bit counter wraps 15 -> 0
      for (int i = 0; i < 16; i++) begin
         repeat ((i == 0) ? 7 : 8) cyc(1, 1, O_LDA, 0, 0);
         chk($sformatf("wrap_main%0d", i), S_F0, C_RD | C_IR, 16'(i + 1));
         chk4($sformatf("wrap_cnt4_%0d", i), 4'((i + 1) % 16));
      end

      // randomized run against the model, from a fresh reset
      #2 rst_n = 1'b0;
      #1 rst_n = 1'b1;
      stuck = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (c % 50 == 0) stuck = ($urandom % 4) == 0;
         rop = 3'($urandom_range(0, 7));
         if (rop == O_HLT && ($urandom % 2) == 0) rop = O_LDA;
         cyc(($urandom % 50) != 0,
             stuck ? 1'b0 : (($urandom % 5) != 0),
             rop, 1'($urandom % 2), ($urandom % 6) == 0);
         cmp_model(c);
         if (($urandom % 400) == 0) begin
            #2 rst_n = 1'b0;
            #1 rst_n = 1'b1;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ctrl_sequencer.md
CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 Parameter OPW, default 3: opcode width; OPW >= 3.
REQ-002 Parameters HLT/SKZ/ADD/ANDD/XORR/LDA/STO/JMP, defaults 0..7: opcode encodings, each OPW bits wide.
REQ-003 Parameter WAIT_MAX, default 15: maximum wait cycles per memory state before error; range 1..255.
REQ-004 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-005 clk  in  1  system clock; all state and registered outputs update on the falling edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 ena  in  1  synchronous run enable, sampled on the falling edge.
REQ-008 opcode_c  in  OPW  current instruction opcode.
REQ-009 zero  in  1  accumulator-zero flag.
REQ-010 mem_rdy  in  1  memory ready; held stable for the whole clock period.
REQ-011 resume  in  1  one-cycle pulse that releases the halt state.
REQ-012 inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt  out  1 each  datapath controls.
REQ-013 err  out  1  memory-timeout error flag.
REQ-014 state_o  out  4  current state encoding.
REQ-015 instr_cnt  out  CNT_W  retired-instruction count.

Function
REQ-016 States: FETCH0=0, FETCH1=1, IDLE=2, DEC=3, OP1=4, OP2=5, OP3=6, OP4=7, HALT=8, ERR=9; codes 10-15 go to FETCH0 with all controls 0.
REQ-017 Moore outputs; any output not listed for a state is 0.
- FETCH0: rd, load_ir.
- FETCH1: inc_pc, rd, load_ir.
- IDLE: none.
- DEC: inc_pc; halt also 1 when opcode_c == HLT.
REQ-018 OP1 outputs: JMP -> load_pc; ADD/ANDD/XORR/LDA -> rd; STO -> datactl_ena; other opcodes -> none.
REQ-019 OP2 outputs: ADD/ANDD/XORR/LDA -> load_acc, rd; SKZ with zero=1 -> inc_pc; JMP -> inc_pc, load_pc; STO -> wr, datactl_ena.
REQ-020 OP3 outputs: STO -> datactl_ena; ADD/ANDD/XORR/LDA -> rd.
REQ-021 OP4 outputs: SKZ with zero=1 -> inc_pc.
REQ-022 HALT outputs: halt. ERR outputs: halt, err.
REQ-023 Transitions:
- FETCH0->FETCH1->IDLE->DEC.
- DEC->HALT when opcode_c == HLT, else DEC->OP1.
- OP1->OP2->OP3->OP4->FETCH0.
REQ-024 Memory state: any state in which rd or wr is 1.
- When mem_rdy=0 at a falling edge, the sequencer stays in the state, keeps rd/wr/datactl_ena, and increments the wait counter.
- When mem_rdy=1 at a falling edge, it advances and clears the wait counter.
REQ-025 In a memory state, inc_pc, load_acc, load_pc and load_ir are gated combinationally with mem_rdy, so each strobe is active for exactly one accepted cycle.
REQ-026 If the wait counter equals WAIT_MAX while mem_rdy=0 at a falling edge, the next state is ERR and the wait counter clears.
REQ-027 ERR is left only by rst_n=0 or ena=0.
REQ-028 HALT is sticky. resume=1 at a falling edge moves HALT to FETCH0. resume is ignored in every other state.
REQ-029 instr_cnt increments by 1, modulo 2^CNT_W, on each OP4->FETCH0 transition. HLT instructions are not counted.
REQ-030 ena=0 at a falling edge forces state FETCH0, all controls 0, err 0 and the wait counter 0. instr_cnt is held. ena=0 has priority over resume, mem_rdy and timeout.
REQ-031 zero and opcode_c are sampled only at the falling edge that registers the outputs; opcode_c changes mid-instruction take effect on the next registered state.

Reset
REQ-032 rst_n=0 immediately, independent of clk, sets:
- state FETCH0;
- all control outputs, err and state_o to 0;
- wait counter 0;
- instr_cnt 0.
REQ-033 After rst_n rises, the first state advance occurs at the first falling edge with ena=1. Reset asserted mid-wait or in HALT/ERR overrides everything.

Verification
REQ-034 ena=1, mem_rdy=1, LDA:
- FETCH0..OP4 sequence of 8 cycles.
- load_acc=1 only in OP2.
- instr_cnt 0->1.
REQ-035 STO with mem_rdy=0 for 3 cycles in OP2:
- OP2 held 4 cycles, wr=1 throughout.
- instr_cnt increments once.
REQ-036 mem_rdy=0 permanently in FETCH0, WAIT_MAX=15:
- ERR entered after 16 cycles in FETCH0, err=1, halt=1.
- ena=0 returns to FETCH0 with err=0.
REQ-037 HLT:
- DEC shows halt=1 and inc_pc=1, then HALT persists for 20 cycles.
- resume pulse -> FETCH0 next cycle; instr_cnt unchanged.
REQ-038 SKZ with zero=1: inc_pc=1 in OP2 and OP4. SKZ with zero=0: inc_pc=0 in OP2 and OP4.
REQ-039 rst_n=0 asserted between clock edges during OP2 wait:
- all outputs 0 and state_o=0 before the next edge.
- CNT_W=4 run of 16 instructions: instr_cnt wraps 15->0.
